// File: rtl/screen_pkg.sv
// Shared state encoding, screen codes and colour constants for the pinball
// screen sequencer.
package screen_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_INTRO,
    S_PLAY,
    S_OVER,
    S_WIN
  } state_t;

  localparam logic [1:0] SCR_START = 2'd0;
  localparam logic [1:0] SCR_MAIN  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;
  localparam logic [1:0] SCR_WIN   = 2'd3;

  localparam logic [7:0] RGB_BLACK = 8'h00;

endpackage

// File: rtl/screen_controller_frame_timer.sv
// Frame-granular down counter: a load value N expires on exactly the N-th
// startOfFrame after the load (a load value of 0 behaves like 1).
module frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       startOfFrame,
  output logic       expired
);

  logic [7:0] cnt;

  assign expired = startOfFrame && (cnt <= 8'd1);

  // A load wins over a coincident frame pulse; the count parks at zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= (load_value == 8'd0) ? 8'd1 : load_value;
    end else if (startOfFrame && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/screen_controller.sv
// Pinball screen sequencer: start/intro/play/over/win screens, game start pulse,
// registered RGB mux and session high score. Optional macro: SCREEN_BLINK_EN.
import screen_pkg::*;

module screen_controller #(
  parameter int         INTRO_FRAMES = 60,
  parameter int         OVER_FRAMES  = 120,
  parameter logic [3:0] WIN_SCORE    = 4'd9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_over,
  output logic [7:0] RGB_out,
  output logic       start,
  output logic [1:0] screen_sel,
  output logic       game_active,
  output logic [3:0] high_score
);

  localparam logic [7:0] INTRO_LOAD = INTRO_FRAMES[7:0];
  localparam logic [7:0] OVER_LOAD  = OVER_FRAMES[7:0];

  state_t     state, state_nx;
  logic       armed, armed_nx;
  logic       key_d, key_rise;
  logic       start_nx;
  logic [3:0] high_score_nx;
  logic       load, expired;
  logic [7:0] load_value;
  logic [7:0] over_pix;

  assign key_rise = key5IsPressed & ~key_d;

  frame_timer u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .load         (load),
    .load_value   (load_value),
    .startOfFrame (startOfFrame),
    .expired      (expired)
  );

  // armed masks stale life/score in PLAY and gates the key in OVER/WIN.
  always_comb begin
    state_nx      = state;
    armed_nx      = armed;
    start_nx      = 1'b0;
    high_score_nx = high_score;
    load          = 1'b0;
    load_value    = OVER_LOAD;
    case (state)
      S_START: begin
        if (key_rise) begin
          state_nx   = S_INTRO;
          load       = 1'b1;
          load_value = INTRO_LOAD;
        end
      end
      S_INTRO: begin
        if (expired) begin
          state_nx = S_PLAY;
          start_nx = 1'b1;
          armed_nx = 1'b0;
        end
      end
      S_PLAY: begin
        if (!armed) begin
          if (startOfFrame) armed_nx = 1'b1;
        end else if ((life == 4'd0) || (score >= WIN_SCORE)) begin
          state_nx = (life == 4'd0) ? S_OVER : S_WIN;
          load     = 1'b1;
          armed_nx = 1'b0;
          if (score > high_score) high_score_nx = score;
        end
      end
      S_OVER, S_WIN: begin
        if (!armed) begin
          if (expired) armed_nx = 1'b1;
        end else if (key_rise) begin
          state_nx = S_START;
        end
      end
      default: state_nx = S_START;
    endcase
  end

  // key_d resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= S_START;
      armed      <= 1'b0;
      key_d      <= 1'b1;
      start      <= 1'b0;
      high_score <= 4'd0;
    end else begin
      state      <= state_nx;
      armed      <= armed_nx;
      key_d      <= key5IsPressed;
      start      <= start_nx;
      high_score <= high_score_nx;
    end
  end

`ifdef SCREEN_BLINK_EN
  logic [4:0] blink_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt <= 5'd0;
    end else if ((state == S_PLAY) && load) begin
      blink_cnt <= 5'd0;
    end else if (startOfFrame) begin
      blink_cnt <= blink_cnt + 5'd1;
    end
  end

  assign over_pix = blink_cnt[4] ? RGB_BLACK : RGB_screen_over;
`else
  assign over_pix = RGB_screen_over;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGB_out <= RGB_BLACK;
    end else begin
      case (state)
        S_START, S_INTRO: RGB_out <= RGB_screen_start;
        S_PLAY:           RGB_out <= RGB_screen_main;
        default:          RGB_out <= over_pix;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_START:        screen_sel = SCR_START;
      S_INTRO,
      S_PLAY:         screen_sel = SCR_MAIN;
      S_OVER:         screen_sel = SCR_OVER;
      S_WIN:          screen_sel = SCR_WIN;
      default:        screen_sel = SCR_START;
    endcase
  end

  assign game_active = (state == S_PLAY);

endmodule

// File: tb/tb_screen_controller.sv
// Randomised bench for screen_controller against a frame-counting reference
// model of the screen rules; every output is compared every cycle.
module tb_screen_controller;

  localparam int INTRO = 3;
  localparam int OVER  = 4;
  localparam int WIN   = 9;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       key5IsPressed;
  logic [3:0] life, score;
  logic [7:0] rgb_start, rgb_main, rgb_over;
  logic [7:0] RGB_out;
  logic       start;
  logic [1:0] screen_sel;
  logic       game_active;
  logic [3:0] high_score;

  int checks   = 0;
  int failures = 0;

  // Model: 0 start, 1 intro, 2 play, 3 over, 4 win; seen = frames since entry.
  int   m_mode, m_seen, m_hs;
  bit   m_keyd, m_start;
  logic [7:0] m_rgb;

  int key_mode;
  bit key_val;
  int life_val, score_val;

  screen_controller #(
    .INTRO_FRAMES (INTRO),
    .OVER_FRAMES  (OVER),
    .WIN_SCORE    (4'd9)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .key5IsPressed    (key5IsPressed),
    .life             (life),
    .score            (score),
    .RGB_screen_start (rgb_start),
    .RGB_screen_main  (rgb_main),
    .RGB_screen_over  (rgb_over),
    .RGB_out          (RGB_out),
    .start            (start),
    .screen_sel       (screen_sel),
    .game_active      (game_active),
    .high_score       (high_score)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [1:0] sel_of(input int mode);
    case (mode)
      0: return 2'd0;
      1, 2: return 2'd1;
      3: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_seen = 0; m_hs = 0; m_keyd = 1'b1; m_start = 1'b0; m_rgb = 8'h00;
  endtask

  task automatic compare_all();
    check_eq("screen_sel", {30'd0, screen_sel}, {30'd0, sel_of(m_mode)});
    check_eq("game_active", {31'd0, game_active}, {31'd0, (m_mode == 2)});
    check_eq("start", {31'd0, start}, {31'd0, m_start});
    check_eq("high_score", {28'd0, high_score}, m_hs);
    check_eq("RGB_out", {24'd0, RGB_out}, {24'd0, m_rgb});
  endtask

  task automatic model_step();
    bit kr;
    int nmode, nseen;
    kr    = key5IsPressed && !m_keyd;
    nmode = m_mode;
    nseen = m_seen + (startOfFrame ? 1 : 0);
    if (m_mode <= 1)      m_rgb = rgb_start;
    else if (m_mode == 2) m_rgb = rgb_main;
`ifdef SCREEN_BLINK_EN
    else                  m_rgb = (((m_seen / 16) % 2) == 1) ? 8'h00 : rgb_over;
`else
    else                  m_rgb = rgb_over;
`endif
    m_start = 1'b0;
    case (m_mode)
      0: if (kr) begin nmode = 1; nseen = 0; end
      1: if (startOfFrame && (m_seen + 1 >= INTRO)) begin
           nmode = 2; nseen = 0; m_start = 1'b1;
         end
      2: if (m_seen >= 1 && (life == 0 || score >= WIN)) begin
           nmode = (life == 0) ? 3 : 4;
           nseen = 0;
           if (score > m_hs) m_hs = score;
         end
      default: if (m_seen >= OVER && kr) begin nmode = 0; nseen = 0; end
    endcase
    m_mode = nmode;
    m_seen = nseen;
    m_keyd = key5IsPressed;
  endtask

  task automatic cycle();
    @(negedge clk);
    startOfFrame = ($urandom_range(0, 5) == 0);
    rgb_start    = 8'($urandom);
    rgb_main     = 8'($urandom);
    rgb_over     = 8'($urandom);
    if (key_mode == 1 && $urandom_range(0, 11) == 0) key_val = !key_val;
    key5IsPressed = key_val;
    if (life_val >= 0) life = 4'(life_val);
    else life = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    if (score_val >= 0) score = 4'(score_val);
    else score = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_mode(input int target, input int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin
      cycle();
      n++;
    end
    check_eq("reach_screen", {30'd0, screen_sel}, {30'd0, sel_of(target)});
  endtask

  task automatic press();
    key_mode = 0;
    key_val = 1'b0; cycle();
    key_val = 1'b1; cycle();
    key_val = 1'b0; cycle();
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; key5IsPressed = 1'b1; key_val = 1'b1;
    key_mode = 0; life_val = 3; score_val = 0;
    life = 4'd3; score = 4'd0; rgb_start = 8'h11; rgb_main = 8'h22; rgb_over = 8'h33;
    model_reset();
    #2;
    compare_all();
    @(posedge clk); @(posedge clk);
    @(negedge clk); resetN = 1'b1;

    // Key held through reset must not start the game.
    run(10);
    key_val = 1'b0; run(3);
    press();
    life_val = 0;
    wait_mode(2, 400);
    life_val = 3; score_val = 4;
    for (int i = 0; i < 400 && m_seen < 2; i++) cycle();
    life_val = 0;
    wait_mode(3, 400);
    check_eq("hs_after_over", {28'd0, high_score}, 32'd4);

    // Key held across expiry, then release and press.
    key_mode = 0; key_val = 1'b1;
    run(80);
    check_eq("held_key_stays_over", {30'd0, screen_sel}, 32'd2);
    press();
    check_eq("over_to_start", {30'd0, screen_sel}, 32'd0);

    // Simultaneous life==0 and win score: game over wins.
    press();
    life_val = 0; score_val = 9;
    wait_mode(2, 400);
    wait_mode(3, 400);
    key_mode = 1;
    wait_mode(0, 2000);

    press();
    life_val = 2; score_val = 9;
    wait_mode(2, 400);
    wait_mode(4, 400);
    check_eq("hs_win", {28'd0, high_score}, 32'd9);
    key_mode = 1;
    wait_mode(0, 2000);

    press();
    life_val = 0; score_val = 5;
    wait_mode(2, 400);
    wait_mode(3, 400);
    check_eq("hs_kept", {28'd0, high_score}, 32'd9);

    key_mode = 1; life_val = -1; score_val = -1;
    run(4000);

    // Asynchronous reset in the middle of play.
    life_val = 5; score_val = 1;
    wait_mode(2, 3000);
    run(3);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); @(posedge clk);
    @(negedge clk); resetN = 1'b1;
    key_mode = 0; key_val = key5IsPressed;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
